light_fader: RTL and testbench
==============================

Name: light_fader

Overview:
- Downstream consumer of the motion detector's main_program enable; drives the lamp.
- When main_program rises, lamp brightness ramps linearly up to full, holds at full, then ramps linearly to off once main_program falls.
- Brightness is delivered as a PWM output plus a visible level bus for status and debug.
- Single clock domain, same clock as the motion detector; main_program is consumed without a synchronizer.

Parameters:
- PWM_BITS, 8, width of the brightness level and the PWM counter; MAX = 2^PWM_BITS-1.
- STEP_CYCLES, 196_078, clocks per one-LSB brightness step; the default gives about a 1 s full ramp at 50 MHz. Legal range is >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- main_program  input  1  lamp request from the motion detector; level-sensitive.
- pwm_out  output  1  registered PWM drive to the lamp driver.
- level  output  PWM_BITS  current target brightness, 0..MAX.
- state  output  2  FSM state: OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3.
- lamp_on  output  1  high whenever state != OFF.

Behaviour:
- Reset (reset=0, asynchronous), all registers cleared:
  - state=OFF, level=0, step_cnt=0, pwm_cnt=0, duty=0, pwm_out=0, lamp_on=0.
- Step tick:
  - step_cnt counts 0..STEP_CYCLES-1 only in RAMP_UP and RAMP_DOWN.
  - tick = (step_cnt == STEP_CYCLES-1); step_cnt wraps to 0 on tick.
  - step_cnt is held at 0 in OFF and ON.
  - step_cnt is cleared on every state change.
- FSM, all transitions on a clk edge:
  - OFF: main_program=1 -> RAMP_UP. level stays 0; the first increment occurs STEP_CYCLES cycles after entry.
  - RAMP_UP:
    - main_program=0 -> RAMP_DOWN, keeping the current level (no jump).
    - Otherwise, on tick: level+1. If the new level == MAX, go to ON on the same edge.
  - ON: main_program=0 -> RAMP_DOWN. level stays MAX.
  - RAMP_DOWN:
    - main_program=1 -> RAMP_UP, keeping the current level.
    - Otherwise, on tick: level-1. If the new level == 0, go to OFF on the same edge.
- Direction reversal has priority over the tick in the same cycle. The level does not change on the reversal edge.
- Full ramp timing: 0->MAX takes MAX*STEP_CYCLES cycles after the RAMP_UP entry edge. MAX->0 takes the same.
- level arithmetic never wraps: it is clamped to 0..MAX by the FSM structure.
- PWM:
  - pwm_cnt is free-running over 0..MAX and wraps.
  - duty is loaded from level only when pwm_cnt == MAX (period boundary), so the duty cycle never changes mid-period.
  - pwm_out is registered: pwm_out <= (duty == MAX) ? 1 : (pwm_cnt < duty).
  - duty=0 gives a constant 0. duty=MAX gives a constant 1 (no glitch low).
  - One cycle of latency from the pwm_cnt/duty compare to pin.
- lamp_on is combinational from state (state != OFF).
- A glitch on main_program shorter than STEP_CYCLES produces a reversal with no level change; no spurious steps.
- Reset asserted mid-ramp: immediate return to OFF with level=0 and pwm_out=0; no ramp-down.

Decomposition:
- Shared package light_pkg contains:
  - state encoding constants: ST_OFF, ST_RAMP_UP, ST_ON, ST_RAMP_DOWN;
  - the MAX derivation from PWM_BITS.
- One sub-module, pwm_gen (PWM_BITS):
  - contains pwm_cnt, the duty shadow register with boundary load, and the registered compare;
  - inputs clk, reset, level; output pwm_out.
- FSM and step timer stay in light_fader.

Test Plan:
All scenarios use PWM_BITS=4 (MAX=15) and STEP_CYCLES=4.
1. Reset release, main_program=0 held for 100 cycles -> state=OFF, level=0, pwm_out=0 throughout, lamp_on=0.
2. main_program 0->1 and held -> RAMP_UP on that edge; level increments every 4 cycles; level=15 and state=ON exactly 60 cycles after entry; pwm_out is constant 1 once duty=15.
3. From ON, main_program falls -> RAMP_DOWN; level reaches 0 and state=OFF 60 cycles later; lamp_on falls on the same edge.
4. Reversal: main_program falls when level=7 during RAMP_UP -> RAMP_DOWN with level still 7; next decrement to 6 occurs exactly 4 cycles later; re-raise at level 5 -> RAMP_UP, level 6 after 4 cycles.
5. PWM check: force level=5 and hold -> after the next pwm_cnt wrap, pwm_out is high 5 of every 16 cycles. Change level mid-period -> the duty change appears only from the following period.
6. Reset asserted at level=9 in RAMP_UP -> outputs go to their reset values asynchronously (state=OFF, level=0, pwm_out=0, lamp_on=0) before the next clk edge; after release with main_program=1, ramp-up restarts from 0.

Source files
------------

// File: rtl/light_fader_pkg.sv
// Shared definitions for the lamp fader: state encoding and brightness range.
package light_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } light_state_t;

  // Full-scale brightness code for a given PWM width.
  function automatic int unsigned light_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/light_fader_pwm_gen.sv
// PWM generator: free-running counter, duty shadow loaded only at the
// period boundary, and a registered compare driving the pin.
module pwm_gen
  import light_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] level,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(light_max(PWM_BITS));

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;

  // Counter wraps naturally; duty follows level only between periods so a
  // period is never cut short. Full scale is forced high to avoid the
  // one-cycle low that a plain compare would give at pwm_cnt == MAX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == MAX) begin
        duty <= level;
      end
      pwm_out <= (duty == MAX) ? 1'b1 : (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/light_fader.sv
// Lamp fader: ramps brightness up while main_program is high, holds at full,
// and ramps back to off after it falls. Brightness leaves as PWM plus a
// status level bus.
//
//   state        | meaning
//   -------------+---------------------------------------------------
//   ST_OFF       | lamp dark, level 0, waiting for main_program
//   ST_RAMP_UP   | level +1 every STEP_CYCLES clocks until MAX
//   ST_ON        | level held at MAX while main_program stays high
//   ST_RAMP_DOWN | level -1 every STEP_CYCLES clocks until 0
module light_fader
  import light_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned STEP_CYCLES = 196_078
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                main_program,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] level,
  output logic [1:0]          state,
  output logic                lamp_on
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(light_max(PWM_BITS));
  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  light_state_t        state_q;
  logic [PWM_BITS-1:0] level_q;
  logic [CNT_W-1:0]    step_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] level_up;
  logic [PWM_BITS-1:0] level_dn;

  // Saturating neighbours of the current level. A reversal right after
  // entering a ramp can leave RAMP_UP at MAX or RAMP_DOWN at 0, so the
  // step must clamp rather than wrap.
  always_comb begin
    tick     = (step_cnt == STEP_LAST);
    level_up = level_q;
    level_dn = level_q;
    if (level_q != MAX) level_up = level_q + PWM_BITS'(1);
    if (level_q != '0)  level_dn = level_q - PWM_BITS'(1);
  end

  // Sequencer and step timer; a reversal wins over a tick on the same edge
  // and never moves the level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_OFF;
      level_q  <= '0;
      step_cnt <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          step_cnt <= '0;
          if (main_program) state_q <= ST_RAMP_UP;
        end
        ST_RAMP_UP: begin
          if (!main_program) begin
            state_q  <= ST_RAMP_DOWN;
            step_cnt <= '0;
          end else if (tick) begin
            step_cnt <= '0;
            level_q  <= level_up;
            if (level_up == MAX) state_q <= ST_ON;
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        ST_ON: begin
          step_cnt <= '0;
          if (!main_program) state_q <= ST_RAMP_DOWN;
        end
        ST_RAMP_DOWN: begin
          if (main_program) begin
            state_q  <= ST_RAMP_UP;
            step_cnt <= '0;
          end else if (tick) begin
            step_cnt <= '0;
            level_q  <= level_dn;
            if (level_dn == '0) state_q <= ST_OFF;
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_q  <= ST_OFF;
          level_q  <= '0;
          step_cnt <= '0;
        end
      endcase
    end
  end

  // Status outputs follow the registered state directly.
  always_comb begin
    state   = state_q;
    level   = level_q;
    lamp_on = (state_q != ST_OFF);
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk     (clk),
    .reset   (reset),
    .level   (level_q),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_light_fader.sv
// Bench for light_fader with PWM_BITS=4, STEP_CYCLES=4.
module tb_light_fader;

  localparam int S_OFF = 0;
  localparam int S_RU  = 1;
  localparam int S_ON  = 2;
  localparam int S_RD  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       main_program = 1'b0;
  logic       pwm_out;
  logic [3:0] level;
  logic [1:0] state;
  logic       lamp_on;

  logic [3:0] pwm_level = 4'd0;
  logic       pwm_ref;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic mp;
    int   cycles;
    int   st;
    int   lv;
    int   pwm;  // -1: not checked during the hold
  } vec_t;

  typedef struct {
    string name;
    int    st;
    int    lv;
    int    lamp;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   pwm_sb[$];

  light_fader #(
    .PWM_BITS    (4),
    .STEP_CYCLES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .main_program (main_program),
    .pwm_out      (pwm_out),
    .level        (level),
    .state        (state),
    .lamp_on      (lamp_on)
  );

  pwm_gen #(
    .PWM_BITS (4)
  ) u_pwm (
    .clk     (clk),
    .reset   (reset),
    .level   (pwm_level),
    .pwm_out (pwm_ref)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic mp, input int cyc, input int st, input int lv, input int pwm);
    vec_t v;
    v.mp = mp; v.cycles = cyc; v.st = st; v.lv = lv; v.pwm = pwm;
    vt.push_back(v);
  endtask

  initial begin
    exp_t e;
    int   m_duty;
    int   highs;
    int   exp_hi;
    int   got;

    // idle after reset
    add(0, 100, S_OFF, 0, 0);
    // full ramp up
    add(1, 1, S_RU, 0, -1);
    add(1, 3, S_RU, 0, -1);
    add(1, 1, S_RU, 1, -1);
    add(1, 55, S_RU, 14, -1);
    add(1, 1, S_ON, 15, -1);
    add(1, 20, S_ON, 15, -1);
    add(1, 32, S_ON, 15, 1);
    // full ramp down
    add(0, 1, S_RD, 15, -1);
    add(0, 3, S_RD, 15, -1);
    add(0, 1, S_RD, 14, -1);
    add(0, 55, S_RD, 1, -1);
    add(0, 1, S_OFF, 0, -1);
    add(0, 40, S_OFF, 0, -1);
    add(0, 20, S_OFF, 0, 0);
    // reversals
    add(1, 1, S_RU, 0, -1);
    add(1, 28, S_RU, 7, -1);
    add(0, 1, S_RD, 7, -1);
    add(0, 3, S_RD, 7, -1);
    add(0, 1, S_RD, 6, -1);
    add(0, 4, S_RD, 5, -1);
    add(1, 1, S_RU, 5, -1);
    add(1, 3, S_RU, 5, -1);
    add(1, 1, S_RU, 6, -1);
    add(1, 3, S_RU, 6, -1);
    add(0, 1, S_RD, 6, -1);   // reversal on a tick edge: no step
    add(0, 23, S_RD, 1, -1);
    add(0, 1, S_OFF, 0, -1);
    // immediate reversal out of OFF must not wrap below 0
    add(1, 1, S_RU, 0, -1);
    add(0, 1, S_RD, 0, -1);
    add(0, 3, S_RD, 0, -1);
    add(0, 1, S_OFF, 0, -1);

    // reset state
    cycles(3);
    chk("rst_state", state, S_OFF);
    chk("rst_level", level, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_lamp", lamp_on, 0);
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      main_program = vt[i].mp;
      e.name = $sformatf("vec%0d", i);
      e.st = vt[i].st;
      e.lv = vt[i].lv;
      e.lamp = (vt[i].st != S_OFF) ? 1 : 0;
      sb.push_back(e);
      for (int c = 0; c < vt[i].cycles; c++) begin
        cycles(1);
        if (vt[i].pwm >= 0) chk($sformatf("vec%0d_pwm_c%0d", i, c), pwm_out, vt[i].pwm);
      end
      e = sb.pop_front();
      chk({e.name, "_state"}, state, e.st);
      chk({e.name, "_level"}, level, e.lv);
      chk({e.name, "_lamp"}, lamp_on, e.lamp);
    end

    // asynchronous reset in the middle of a ramp
    main_program = 1'b1;
    cycles(37);
    chk("mid_state", state, S_RU);
    chk("mid_level", level, 9);
    #2 reset = 1'b0;
    #1;
    chk("async_state", state, S_OFF);
    chk("async_level", level, 0);
    chk("async_pwm", pwm_out, 0);
    chk("async_lamp", lamp_on, 0);
    cycles(2);
    reset = 1'b1;
    cycles(1);
    chk("restart_state", state, S_RU);
    chk("restart_level0", level, 0);
    cycles(3);
    chk("restart_level0b", level, 0);
    cycles(1);
    chk("restart_level1", level, 1);

    // PWM with a held level and a mid-period change
    main_program = 1'b0;
    reset = 1'b0;
    pwm_level = 4'd5;
    cycles(2);
    reset = 1'b1;
    m_duty = 0;
    highs = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      pwm_sb.push_back((m_duty == 15) ? 1 : ((((k - 1) % 16) < m_duty) ? 1 : 0));
      if (k % 16 == 0) m_duty = pwm_level;
      #1;
      got = pwm_sb.pop_front();
      chk($sformatf("pwm_k%0d", k), pwm_ref, got);
      if (pwm_ref === 1'b1) highs++;
      if (k % 16 == 0) begin
        case (k)
          16: exp_hi = 0;
          32: exp_hi = 5;
          48: exp_hi = 5;
          default: exp_hi = 9;
        endcase
        chk($sformatf("pwm_highs_k%0d", k), highs, exp_hi);
        highs = 0;
      end
      if (k == 40) pwm_level = 4'd9;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
